// File: rtl/cache_axi_bridge_if.sv
// AXI3 master-port bundle between cache_axi_bridge and the core_top AXI pins.
interface cache_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );
endinterface

// File: rtl/cache_axi_bridge.sv
// Icache/dcache refill and writeback bridge onto one AXI3 master port: one read and one write in flight.
// Define BRIDGE_RR_ARB_EN for round-robin read arbitration (default: fixed dcache priority).
module cache_axi_bridge #(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [3:0]  ICACHE_ID  = 4'd0,
    parameter logic [3:0]  DCACHE_ID  = 4'd1
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       i_rd_req,
    input  logic [2:0]                 i_rd_type,
    input  logic [31:0]                i_rd_addr,
    output logic                       i_rd_rdy,
    output logic                       i_ret_valid,
    output logic                       i_ret_last,
    output logic [31:0]                i_ret_data,

    input  logic                       d_rd_req,
    input  logic [2:0]                 d_rd_type,
    input  logic [31:0]                d_rd_addr,
    output logic                       d_rd_rdy,
    output logic                       d_ret_valid,
    output logic                       d_ret_last,
    output logic [31:0]                d_ret_data,

    input  logic                       d_wr_req,
    input  logic [2:0]                 d_wr_type,
    input  logic [31:0]                d_wr_addr,
    input  logic [3:0]                 d_wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]   d_wr_data,
    output logic                       d_wr_rdy,

    cache_axi_bridge_if.master         axi
);
    localparam int unsigned OFF = $clog2(4 * LINE_WORDS);
    localparam int unsigned CW  = $clog2(LINE_WORDS);
    localparam logic [2:0]  TYPE_LINE = 3'd4;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

    function automatic logic [7:0] burst_len(input logic [2:0] t);
        return (t == TYPE_LINE) ? 8'(LINE_WORDS - 1) : 8'd0;
    endfunction

    function automatic logic [2:0] beat_size(input logic [2:0] t);
        return (t == TYPE_LINE) ? 3'd2 : {1'b0, t[1:0]};
    endfunction

    r_state_t        r_state;
    w_state_t        w_state;
    logic            r_owner_d;
    logic            raw_hit;
    logic            i_grant;
    logic            d_grant;
    logic [2:0]      gnt_type;
    logic [31:0]     gnt_addr;
    logic [CW-1:0]   beat;
    logic [3:0]      wstrb_q;
    logic            w_last_beat;
    logic [31:0]     wbuf [LINE_WORDS];
    logic            unused_axi;
`ifdef BRIDGE_RR_ARB_EN
    logic            last_gnt_d;
`endif

    // Grant logic; a RAW-blocked dcache read still keeps the icache out that cycle.
    always_comb begin
        raw_hit = (w_state != W_IDLE) && (d_rd_addr[31:OFF] == axi.awaddr[31:OFF]);
        i_grant = 1'b0;
        d_grant = 1'b0;
        if (r_state == R_IDLE) begin
`ifdef BRIDGE_RR_ARB_EN
            if (d_rd_req && !(i_rd_req && last_gnt_d)) d_grant = !raw_hit;
            else                                       i_grant = i_rd_req;
`else
            if (d_rd_req) d_grant = !raw_hit;
            else          i_grant = i_rd_req;
`endif
        end
    end

    assign gnt_type = d_grant ? d_rd_type : i_rd_type;
    assign gnt_addr = d_grant ? d_rd_addr : i_rd_addr;
    assign i_rd_rdy = i_grant;
    assign d_rd_rdy = d_grant;

    assign i_ret_valid = axi.rready & axi.rvalid & ~r_owner_d;
    assign d_ret_valid = axi.rready & axi.rvalid &  r_owner_d;
    assign i_ret_last  = i_ret_valid & axi.rlast;
    assign d_ret_last  = d_ret_valid & axi.rlast;
    assign i_ret_data  = axi.rdata;
    assign d_ret_data  = axi.rdata;
    assign axi.arburst = 2'b01;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= R_IDLE;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            axi.araddr  <= '0;
            axi.arlen   <= '0;
            axi.arsize  <= '0;
            axi.arid    <= '0;
            r_owner_d   <= 1'b0;
`ifdef BRIDGE_RR_ARB_EN
            last_gnt_d  <= 1'b0;
`endif
        end else begin
            case (r_state)
                R_IDLE: if (i_grant || d_grant) begin
                    axi.arvalid <= 1'b1;
                    axi.araddr  <= gnt_addr;
                    axi.arlen   <= burst_len(gnt_type);
                    axi.arsize  <= beat_size(gnt_type);
                    axi.arid    <= d_grant ? DCACHE_ID : ICACHE_ID;
                    r_owner_d   <= d_grant;
`ifdef BRIDGE_RR_ARB_EN
                    last_gnt_d  <= d_grant;
`endif
                    r_state     <= R_AR;
                end
                R_AR: if (axi.arready) begin
                    axi.arvalid <= 1'b0;
                    axi.rready  <= 1'b1;
                    r_state     <= R_DATA;
                end
                R_DATA: if (axi.rvalid && axi.rlast) begin
                    axi.rready  <= 1'b0;
                    r_state     <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign d_wr_rdy    = (w_state == W_IDLE);
    assign w_last_beat = (8'(beat) == axi.awlen);
    assign axi.awburst = 2'b01;
    assign axi.awid    = DCACHE_ID;
    assign axi.wid     = DCACHE_ID;
    assign axi.wdata   = wbuf[beat];
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = axi.wvalid & w_last_beat;

    // Line buffer holds the write payload once accepted; the client may change d_wr_data afterwards.
    always_ff @(posedge clk) begin
        if (d_wr_rdy && d_wr_req) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) wbuf[i] <= d_wr_data[32*i +: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state     <= W_IDLE;
            axi.awvalid <= 1'b0;
            axi.awaddr  <= '0;
            axi.awlen   <= '0;
            axi.awsize  <= '0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            beat        <= '0;
            wstrb_q     <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (d_wr_req) begin
                    axi.awvalid <= 1'b1;
                    axi.awaddr  <= d_wr_addr;
                    axi.awlen   <= burst_len(d_wr_type);
                    axi.awsize  <= beat_size(d_wr_type);
                    wstrb_q     <= (d_wr_type == TYPE_LINE) ? 4'hF : d_wr_wstrb;
                    w_state     <= W_AW;
                end
                W_AW: if (axi.awready) begin
                    axi.awvalid <= 1'b0;
                    axi.wvalid  <= 1'b1;
                    beat        <= '0;
                    w_state     <= W_DATA;
                end
                W_DATA: if (axi.wready) begin
                    if (w_last_beat) begin
                        axi.wvalid <= 1'b0;
                        axi.bready <= 1'b1;
                        w_state    <= W_RESP;
                    end else begin
                        beat <= beat + CW'(1);
                    end
                end
                W_RESP: if (axi.bvalid) begin
                    axi.bready <= 1'b0;
                    w_state    <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign unused_axi = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: directed vector table, multi-cycle corner sequences, random traffic.
module tb_cache_axi_bridge;
    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic reset;
    logic i_rd_req, d_rd_req, d_wr_req;
    logic [2:0] i_rd_type, d_rd_type, d_wr_type;
    logic [31:0] i_rd_addr, d_rd_addr, d_wr_addr;
    logic [3:0] d_wr_wstrb;
    logic [32*LW-1:0] d_wr_data;
    logic i_rd_rdy, d_rd_rdy, d_wr_rdy;
    logic i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    logic [31:0] i_ret_data, d_ret_data;

    cache_axi_bridge_if axi();

    cache_axi_bridge #(.LINE_WORDS(LW), .ICACHE_ID(4'd0), .DCACHE_ID(4'd1)) dut (
        .clk(clk), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
        .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .axi(axi)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit last_d = 1'b0;

    typedef struct {
        logic        is_d;
        logic [2:0]  typ;
        logic [31:0] addr;
        int          dly;
        logic [7:0]  e_len;
        logic [2:0]  e_size;
        logic [3:0]  e_id;
    } rd_vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference rules: line ops burst LW words of 4 bytes, everything else is one beat of 2^type bytes.
    function automatic logic [7:0] m_len(input logic [2:0] t);
        return (t == 3'd4) ? 8'(LW - 1) : 8'd0;
    endfunction
    function automatic logic [2:0] m_size(input logic [2:0] t);
        return (t == 3'd4) ? 3'd2 : t;
    endfunction
    function automatic int m_beats(input logic [2:0] t);
        return (t == 3'd4) ? LW : 1;
    endfunction

    task automatic rd_accept(input bit is_d, input logic [2:0] typ, input logic [31:0] addr);
        if (is_d) begin d_rd_req = 1'b1; d_rd_type = typ; d_rd_addr = addr; end
        else      begin i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr; end
        settle();
        chk(is_d ? "d_rd_rdy" : "i_rd_rdy", 64'(is_d ? d_rd_rdy : i_rd_rdy), 64'd1);
        tick();
        d_rd_req = 1'b0; i_rd_req = 1'b0;
        d_rd_addr = $urandom; i_rd_addr = $urandom;
        d_rd_type = 3'($urandom); i_rd_type = 3'($urandom);
        last_d = is_d;
    endtask

    task automatic ar_r_phase(input bit is_d, input logic [31:0] addr, input int dly,
                              input logic [7:0] e_len, input logic [2:0] e_size, input logic [3:0] e_id);
        logic [31:0] dat;
        for (int c = 0; c <= dly; c++) begin
            axi.arready = (c == dly);
            settle();
            chk("arvalid_hold", 64'(axi.arvalid), 64'd1);
            chk("araddr", 64'(axi.araddr), 64'(addr));
            if (c == 0) begin
                chk("arlen", 64'(axi.arlen), 64'(e_len));
                chk("arsize", 64'(axi.arsize), 64'(e_size));
                chk("arid", 64'(axi.arid), 64'(e_id));
                chk("arburst", 64'(axi.arburst), 64'd1);
            end
            tick();
        end
        axi.arready = 1'b0;
        chk("arvalid_drop", 64'(axi.arvalid), 64'd0);
        chk("rready_on", 64'(axi.rready), 64'd1);
        for (int k = 0; k <= int'(e_len); k++) begin
            for (int g = 0; g < int'($urandom_range(2)); g++) begin
                axi.rvalid = 1'b0;
                settle();
                chk("ret_idle", 64'(i_ret_valid | d_ret_valid), 64'd0);
                tick();
            end
            dat = $urandom;
            axi.rvalid = 1'b1; axi.rdata = dat; axi.rlast = (k == int'(e_len));
            axi.rid = e_id; axi.rresp = 2'($urandom);
            settle();
            chk("ret_valid_owner", 64'(is_d ? d_ret_valid : i_ret_valid), 64'd1);
            chk("ret_valid_other", 64'(is_d ? i_ret_valid : d_ret_valid), 64'd0);
            chk("ret_data", 64'(is_d ? d_ret_data : i_ret_data), 64'(dat));
            chk("ret_last", 64'(is_d ? d_ret_last : i_ret_last), 64'(k == int'(e_len)));
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        chk("rready_off", 64'(axi.rready), 64'd0);
    endtask

    task automatic wr_accept(input logic [2:0] typ, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [32*LW-1:0] data);
        d_wr_req = 1'b1; d_wr_type = typ; d_wr_addr = addr; d_wr_wstrb = strb; d_wr_data = data;
        settle();
        chk("d_wr_rdy", 64'(d_wr_rdy), 64'd1);
        tick();
        d_wr_req = 1'b0;
        d_wr_addr = $urandom; d_wr_wstrb = 4'($urandom); d_wr_type = 3'($urandom);
        d_wr_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wr_finish(input logic [2:0] typ, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [32*LW-1:0] data, input int aw_dly, input int mode, input int b_dly);
        int n;
        int k;
        logic [3:0] e_strb;
        n = m_beats(typ);
        e_strb = (typ == 3'd4) ? 4'hF : strb;
        for (int c = 0; c <= aw_dly; c++) begin
            axi.awready = (c == aw_dly);
            settle();
            chk("awvalid_hold", 64'(axi.awvalid), 64'd1);
            chk("wvalid_before_aw", 64'(axi.wvalid), 64'd0);
            chk("d_wr_rdy_busy", 64'(d_wr_rdy), 64'd0);
            if (d_rd_req) chk("raw_hold", 64'(d_rd_rdy), 64'd0);
            if (c == 0) begin
                chk("awaddr", 64'(axi.awaddr), 64'(addr));
                chk("awlen", 64'(axi.awlen), 64'(m_len(typ)));
                chk("awsize", 64'(axi.awsize), 64'(m_size(typ)));
                chk("awburst", 64'(axi.awburst), 64'd1);
                chk("awid", 64'(axi.awid), 64'd1);
            end
            tick();
        end
        axi.awready = 1'b0;
        chk("awvalid_drop", 64'(axi.awvalid), 64'd0);
        k = 0;
        for (int c = 0; c < 64 && k < n; c++) begin
            axi.wready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(1));
            settle();
            chk("wvalid", 64'(axi.wvalid), 64'd1);
            if (d_rd_req) chk("raw_hold", 64'(d_rd_rdy), 64'd0);
            if (axi.wready) begin
                chk("wdata", 64'(axi.wdata), 64'(data[32*k +: 32]));
                chk("wstrb", 64'(axi.wstrb), 64'(e_strb));
                chk("wlast", 64'(axi.wlast), 64'(k == n - 1));
                chk("wid", 64'(axi.wid), 64'd1);
                k++;
            end
            tick();
        end
        axi.wready = 1'b0;
        chk("w_beats", 64'(k), 64'(n));
        chk("wvalid_drop", 64'(axi.wvalid), 64'd0);
        for (int c = 0; c < b_dly; c++) begin
            chk("bready_wait", 64'(axi.bready), 64'd1);
            if (d_rd_req) chk("raw_hold", 64'(d_rd_rdy), 64'd0);
            tick();
        end
        chk("bready_on", 64'(axi.bready), 64'd1);
        axi.bvalid = 1'b1; axi.bid = 4'd1; axi.bresp = 2'($urandom);
        settle();
        if (d_rd_req) chk("raw_hold_b", 64'(d_rd_rdy), 64'd0);
        tick();
        axi.bvalid = 1'b0;
        chk("bready_off", 64'(axi.bready), 64'd0);
        chk("d_wr_rdy_again", 64'(d_wr_rdy), 64'd1);
    endtask

    // Simultaneous word reads; expected winner follows the arbitration policy and the last grant.
    task automatic sim_pair(input logic [31:0] a_i, input logic [31:0] a_d);
        bit d_first;
`ifdef BRIDGE_RR_ARB_EN
        d_first = !last_d;
`else
        d_first = 1'b1;
`endif
        i_rd_req = 1'b1; i_rd_type = 3'd2; i_rd_addr = a_i;
        d_rd_req = 1'b1; d_rd_type = 3'd2; d_rd_addr = a_d;
        settle();
        chk("pair_d_rdy", 64'(d_rd_rdy), 64'(d_first));
        chk("pair_i_rdy", 64'(i_rd_rdy), 64'(!d_first));
        tick();
        if (d_first) begin
            d_rd_req = 1'b0; last_d = 1'b1;
            settle();
            chk("i_held", 64'(i_rd_rdy), 64'd0);
            ar_r_phase(1'b1, a_d, 0, 8'd0, 3'd2, 4'd1);
            settle();
            chk("i_after_d", 64'(i_rd_rdy), 64'd1);
            tick();
            i_rd_req = 1'b0; last_d = 1'b0;
            ar_r_phase(1'b0, a_i, 0, 8'd0, 3'd2, 4'd0);
        end else begin
            i_rd_req = 1'b0; last_d = 1'b0;
            settle();
            chk("d_held", 64'(d_rd_rdy), 64'd0);
            ar_r_phase(1'b0, a_i, 0, 8'd0, 3'd2, 4'd0);
            settle();
            chk("d_after_i", 64'(d_rd_rdy), 64'd1);
            tick();
            d_rd_req = 1'b0; last_d = 1'b1;
            ar_r_phase(1'b1, a_d, 0, 8'd0, 3'd2, 4'd1);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, 64'(axi.arvalid), 64'd0);
        chk({tag, "_rready"}, 64'(axi.rready), 64'd0);
        chk({tag, "_awvalid"}, 64'(axi.awvalid), 64'd0);
        chk({tag, "_wvalid"}, 64'(axi.wvalid), 64'd0);
        chk({tag, "_bready"}, 64'(axi.bready), 64'd0);
        chk({tag, "_d_wr_rdy"}, 64'(d_wr_rdy), 64'd1);
        chk({tag, "_ret_valid"}, 64'(i_ret_valid | d_ret_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rd_vec_t tbl[6];
        logic [2:0] typs[4];
        logic [32*LW-1:0] data;
        logic [31:0] dat;
        logic [2:0] typ;
        logic [31:0] addr;
        logic [3:0] strb;
        int op;

        tbl[0] = '{1'b0, 3'd4, 32'h1C000040, 1, 8'd3, 3'd2, 4'd0};
        tbl[1] = '{1'b1, 3'd2, 32'h00000104, 0, 8'd0, 3'd2, 4'd1};
        tbl[2] = '{1'b1, 3'd0, 32'h00000203, 2, 8'd0, 3'd0, 4'd1};
        tbl[3] = '{1'b0, 3'd1, 32'h1C000012, 0, 8'd0, 3'd1, 4'd0};
        tbl[4] = '{1'b1, 3'd4, 32'h80001230, 3, 8'd3, 3'd2, 4'd1};
        tbl[5] = '{1'b0, 3'd2, 32'h1C0000FC, 1, 8'd0, 3'd2, 4'd0};
        typs[0] = 3'd0; typs[1] = 3'd1; typs[2] = 3'd2; typs[3] = 3'd4;

        reset = 1'b1;
        i_rd_req = 1'b0; i_rd_type = 3'd0; i_rd_addr = '0;
        d_rd_req = 1'b0; d_rd_type = 3'd0; d_rd_addr = '0;
        d_wr_req = 1'b0; d_wr_type = 3'd0; d_wr_addr = '0; d_wr_wstrb = '0; d_wr_data = '0;
        axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;
        tick(); tick();
        chk_idle_outputs("in_reset");
        reset = 1'b0;
        tick();
        chk_idle_outputs("after_reset");

        for (int v = 0; v < 6; v++) begin
            rd_accept(tbl[v].is_d, tbl[v].typ, tbl[v].addr);
            ar_r_phase(tbl[v].is_d, tbl[v].addr, tbl[v].dly, tbl[v].e_len, tbl[v].e_size, tbl[v].e_id);
        end

        sim_pair(32'h1C000100, 32'h00000400);
        sim_pair(32'h1C000104, 32'h00000408);

        data = {32'h44, 32'h33, 32'h22, 32'h11};
        wr_accept(3'd4, 32'h00001000, 4'h0, data);
        wr_finish(3'd4, 32'h00001000, 4'h0, data, 1, 1, 2);

        data = {96'h0, 32'h00AB0000};
        wr_accept(3'd0, 32'h00001002, 4'b0100, data);
        wr_finish(3'd0, 32'h00001002, 4'b0100, data, 0, 0, 0);

        // RAW window: same-line dcache read blocked (and icache kept out) until the write retires.
        rd_accept(1'b0, 3'd2, 32'h1C000200);
        ar_r_phase(1'b0, 32'h1C000200, 0, 8'd0, 3'd2, 4'd0);
        data = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
        wr_accept(3'd4, 32'h00001000, 4'h0, data);
        d_rd_req = 1'b1; d_rd_type = 3'd2; d_rd_addr = 32'h00001008;
        i_rd_req = 1'b1; i_rd_type = 3'd2; i_rd_addr = 32'h1C000300;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("raw_d_blocked", 64'(d_rd_rdy), 64'd0);
            chk("raw_i_no_overtake", 64'(i_rd_rdy), 64'd0);
            tick();
        end
        i_rd_req = 1'b0;
        rd_accept(1'b1, 3'd2, 32'h00002000);
        ar_r_phase(1'b1, 32'h00002000, 0, 8'd0, 3'd2, 4'd1);
        d_rd_req = 1'b1; d_rd_type = 3'd2; d_rd_addr = 32'h00001008;
        wr_finish(3'd4, 32'h00001000, 4'h0, data, 0, 0, 1);
        rd_accept(1'b1, 3'd2, 32'h00001008);
        ar_r_phase(1'b1, 32'h00001008, 0, 8'd0, 3'd2, 4'd1);

        // Reset landing on the second beat of an icache line read.
        rd_accept(1'b0, 3'd4, 32'h1C000080);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("rst_seq_rready", 64'(axi.rready), 64'd1);
        dat = $urandom;
        axi.rvalid = 1'b1; axi.rdata = dat; axi.rlast = 1'b0;
        settle();
        chk("rst_seq_beat1", 64'(i_ret_valid), 64'd1);
        tick();
        reset = 1'b1;
        settle();
        chk("rst_rready", 64'(axi.rready), 64'd0);
        chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
        chk("rst_ret_valid", 64'(i_ret_valid), 64'd0);
        tick();
        reset = 1'b0;
        last_d = 1'b0;
        for (int c = 0; c < 3; c++) begin
            axi.rlast = (c == 2);
            settle();
            chk("post_rst_ret", 64'(i_ret_valid | d_ret_valid), 64'd0);
            chk("post_rst_rready", 64'(axi.rready), 64'd0);
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        chk_idle_outputs("post_rst");
        rd_accept(1'b0, 3'd4, 32'h1C000080);
        ar_r_phase(1'b0, 32'h1C000080, 0, m_len(3'd4), m_size(3'd4), 4'd0);

        for (int t = 0; t < 30; t++) begin
            op = int'($urandom_range(2));
            typ = typs[$urandom_range(3)];
            addr = $urandom;
            if (op < 2) begin
                rd_accept(op == 1, typ, addr);
                ar_r_phase(op == 1, addr, int'($urandom_range(3)), m_len(typ), m_size(typ),
                           (op == 1) ? 4'd1 : 4'd0);
            end else begin
                data = {$urandom, $urandom, $urandom, $urandom};
                strb = 4'($urandom);
                wr_accept(typ, addr, strb, data);
                wr_finish(typ, addr, strb, data, int'($urandom_range(2)), 2, int'($urandom_range(2)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
